// File: rtl/sys_mem.sv
// sys_mem: word-addressed 32-bit single-port memory. It is the responder end of
// the SysMux memory interface and answers each accepted request after a fixed
// number of cycles.
//
// Handshake: a request (memRead|memWrite) is accepted on a rising edge when the
// block is in IDLE or RESP and rst is low. memAddr/memData are sampled on that
// same edge. Writes land in the array at acceptance and return the old word
// (swap). The response appears on memQ with a one-cycle memPush pulse in the
// LATENCY-th cycle after acceptance. memBusy is high in between, and any strobe
// seen while memBusy is high is dropped without side effects. memErr is
// meaningful only while memPush is high.
module sys_mem #(
  parameter int    ADDR_BITS = 10,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] memQ,
  output logic        memPush,
  output logic        memBusy,
  output logic        memErr,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // WAIT counts down from LATENCY-2 so that RESP lands in the LATENCY-th cycle.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            hold_q, hold_d;
  logic                   hold_err_q, hold_err_d;
  logic [31:0]            q_q, q_d;
  logic                   err_q, err_d;
  logic [31:0]            mem_q [DEPTH];

  logic [ADDR_BITS-1:0]   idx;
  logic                   bad;
  logic                   accept;
  logic                   do_write;
  logic [31:0]            resp_now;

  assign idx      = memAddr[ADDR_BITS+1:2];
  assign bad      = (memAddr[1:0] != 2'b00) || (memAddr[31:ADDR_BITS+2] != '0);
  assign accept   = !rst && ((state_q == S_IDLE) || (state_q == S_RESP))
                    && (memRead || memWrite);
  assign do_write = accept && memWrite && !bad;
  // Bad addresses answer zero; a good one returns the word before this edge.
  assign resp_now = bad ? 32'd0 : mem_q[idx];

  // Next-state, latency countdown and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    q_d        = q_q;
    err_d      = err_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      hold_d     = resp_now;
      hold_err_d = bad;
      cnt_d      = CNT_INIT;
      state_d    = (LATENCY == 1) ? S_RESP : S_WAIT;
    end

    // memQ only changes on entry to a push cycle; with LATENCY=1 that is the
    // acceptance edge itself, so the fresh response bypasses the holding reg.
    if (accept && (LATENCY == 1)) begin
      q_d   = resp_now;
      err_d = bad;
    end else if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
      q_d   = hold_q;
      err_d = hold_err_q;
    end
  end

  // Control and response registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      hold_q     <= 32'd0;
      hold_err_q <= 1'b0;
      q_q        <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      q_q        <= q_d;
      err_q      <= err_d;
    end
  end

  // Array write at acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[idx] <= memData;
  end

  assign memQ        = q_q;
  assign memPush     = (state_q == S_RESP);
  assign memBusy     = (state_q == S_WAIT);
  assign memErr      = memPush && err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sys_mem.sv
// Bench for sys_mem: three instances (LATENCY 3, 4 and 1) driven by directed
// vectors. Each issued request pushes {push cycle, check-data flag, err, data}
// into that instance's expected queue; a monitor pops on every memPush.
module tb_sys_mem;

  localparam int LAT0 = 3;
  localparam int LAT1 = 4;
  localparam int LAT2 = 1;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic [2:0]  rd_v;
  logic [2:0]  wr_v;
  logic [31:0] addr_v [3];
  logic [31:0] data_v [3];
  logic [31:0] q_v [3];
  logic [2:0]  push_v;
  logic [2:0]  busy_v;
  logic [2:0]  err_v;
  logic [1:0]  st_v [3];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: [49:34] push cycle, [33] check data, [32] err, [31:0] data.
  logic [49:0] exp_q0[$];
  logic [49:0] exp_q1[$];
  logic [49:0] exp_q2[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_mem #(.ADDR_BITS(10), .LATENCY(LAT0)) u_a (
    .clk(clk), .rst(rst_v[0]), .memAddr(addr_v[0]), .memData(data_v[0]),
    .memRead(rd_v[0]), .memWrite(wr_v[0]), .memQ(q_v[0]), .memPush(push_v[0]),
    .memBusy(busy_v[0]), .memErr(err_v[0]), .dbg_state_o(st_v[0])
  );
  sys_mem #(.ADDR_BITS(10), .LATENCY(LAT1)) u_b (
    .clk(clk), .rst(rst_v[1]), .memAddr(addr_v[1]), .memData(data_v[1]),
    .memRead(rd_v[1]), .memWrite(wr_v[1]), .memQ(q_v[1]), .memPush(push_v[1]),
    .memBusy(busy_v[1]), .memErr(err_v[1]), .dbg_state_o(st_v[1])
  );
  sys_mem #(.ADDR_BITS(10), .LATENCY(LAT2)) u_c (
    .clk(clk), .rst(rst_v[2]), .memAddr(addr_v[2]), .memData(data_v[2]),
    .memRead(rd_v[2]), .memWrite(wr_v[2]), .memQ(q_v[2]), .memPush(push_v[2]),
    .memBusy(busy_v[2]), .memErr(err_v[2]), .dbg_state_o(st_v[2])
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0:       return LAT0;
      1:       return LAT1;
      default: return LAT2;
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [49:0] q_front(input int k);
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_drop(input int k);
    case (k)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input logic [49:0] e);
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Present strobes for one cycle (called at a negedge, returns at the next).
  task automatic fire(input int k, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d);
    rd_v[k]   = rd;
    wr_v[k]   = wr;
    addr_v[k] = a;
    data_v[k] = d;
    @(negedge clk);
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
  endtask

  // A request that must be accepted; its response is expected LATENCY cycles on.
  task automatic issue(input int k, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic chk_data, input logic e_err, input logic [31:0] e_data);
    logic [15:0] ec;
    check($sformatf("busy_at_issue_dut%0d", k), {31'b0, busy_v[k]}, 32'd0);
    ec = 16'(cyc + lat_of(k));
    q_push(k, {ec, chk_data, e_err, e_data});
    fire(k, rd, wr, a, d);
  endtask

  // A strobe presented while busy; it must be dropped.
  task automatic strobe_busy(input int k, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
    check($sformatf("busy_during_drop_dut%0d", k), {31'b0, busy_v[k]}, 32'd1);
    fire(k, rd, wr, a, d);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_one(input int k);
    logic [49:0] e;
    if (push_v[k]) begin
      if (q_size(k) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push_dut%0d: got push with memQ 0x%08h, required no push (cycle %0d)",
                 k, q_v[k], cyc);
      end else begin
        e = q_front(k);
        q_drop(k);
        check($sformatf("push_cycle_dut%0d", k), 32'(cyc), {16'b0, e[49:34]});
        check($sformatf("err_at_push_dut%0d", k), {31'b0, err_v[k]}, {31'b0, e[32]});
        if (e[33]) check($sformatf("memQ_at_push_dut%0d", k), q_v[k], e[31:0]);
      end
    end else begin
      check($sformatf("err_idle_dut%0d", k), {31'b0, err_v[k]}, 32'd0);
      if (q_size(k) != 0) begin
        e = q_front(k);
        if (int'(e[49:34]) <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_push_dut%0d: got no push, required push by cycle %0d (cycle %0d)",
                   k, e[49:34], cyc);
          q_drop(k);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) monitor_one(k);
  end

  // ---------------- stimulus ----------------
  initial begin
    int remain;
    rst_v = 3'b111;
    rd_v  = 3'b111;
    wr_v  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = 32'h0;
      data_v[k] = 32'h0;
    end

    // Reset held two cycles with a read strobe: outputs stay quiet.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rst_memQ_dut%0d", k), q_v[k], 32'd0);
        check($sformatf("rst_push_dut%0d", k), {31'b0, push_v[k]}, 32'd0);
        check($sformatf("rst_busy_dut%0d", k), {31'b0, busy_v[k]}, 32'd0);
      end
    end
    rst_v = 3'b000;
    rd_v  = 3'b000;
    settle(2);

    // ----- instance A, LATENCY 3: each next issue lands in the push cycle -----
    issue(0, 0, 1, 32'h10, 32'h1111_1111, 0, 0, 32'h0);          settle(2);
    issue(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 32'h1111_1111);   settle(2);
    issue(0, 1, 0, 32'h10, 32'h0,         1, 0, 32'hDEAD_BEEF);   settle(2);
    // Busy drop: write strobes during the read's wait cycles are ignored.
    issue(0, 0, 1, 32'h20, 32'h2222_2222, 0, 0, 32'h0);          settle(2);
    issue(0, 1, 0, 32'h20, 32'h0,         1, 0, 32'h2222_2222);
    strobe_busy(0, 0, 1, 32'h20, 32'h1);
    strobe_busy(0, 0, 1, 32'h20, 32'h1);
    issue(0, 1, 0, 32'h20, 32'h0,         1, 0, 32'h2222_2222);   settle(2);
    // Bad addresses: out-of-range read, misaligned write, out-of-range write.
    issue(0, 0, 1, 32'h0,    32'h3333_3333, 0, 0, 32'h0);        settle(2);
    issue(0, 1, 0, 32'h1000, 32'h0,         1, 1, 32'h0);        settle(2);
    issue(0, 0, 1, 32'h3,    32'hFFFF_FFFF, 1, 1, 32'h0);        settle(2);
    issue(0, 1, 0, 32'h0,    32'h0,         1, 0, 32'h3333_3333); settle(2);
    issue(0, 0, 1, 32'h1010, 32'h4444_4444, 1, 1, 32'h0);        settle(2);
    issue(0, 1, 0, 32'h10,   32'h0,         1, 0, 32'hDEAD_BEEF); settle(2);
    // Top word of the array.
    issue(0, 0, 1, 32'hFFC,  32'hABCD_0123, 0, 0, 32'h0);        settle(2);
    issue(0, 1, 0, 32'hFFC,  32'h0,         1, 0, 32'hABCD_0123); settle(2);
    // Simultaneous strobes act as a swap.
    issue(0, 0, 1, 32'h40,   32'h5,         0, 0, 32'h0);        settle(2);
    issue(0, 1, 1, 32'h40,   32'h9,         1, 0, 32'h5);        settle(2);
    issue(0, 1, 0, 32'h40,   32'h0,         1, 0, 32'h9);        settle(3);

    // ----- instance B, LATENCY 4: reset aborts an in-flight read -----
    fire(1, 1, 0, 32'h0, 32'h0);
    check("busy_inflight_dut1", {31'b0, busy_v[1]}, 32'd1);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    check("abort_push_dut1", {31'b0, push_v[1]}, 32'd0);
    check("abort_busy_dut1", {31'b0, busy_v[1]}, 32'd0);
    settle(8);
    // An aborted write still took effect at acceptance.
    fire(1, 0, 1, 32'hC, 32'h55);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    rst_v[1] = 1'b0;
    issue(1, 1, 0, 32'hC, 32'h0, 1, 0, 32'h55);                  settle(4);
    // A write strobed together with rst is not performed.
    rst_v[1]  = 1'b1;
    wr_v[1]   = 1'b1;
    addr_v[1] = 32'hC;
    data_v[1] = 32'h99;
    @(negedge clk);
    rst_v[1] = 1'b0;
    wr_v[1]  = 1'b0;
    issue(1, 1, 0, 32'hC, 32'h0, 1, 0, 32'h55);                  settle(5);

    // ----- instance C, LATENCY 1: one request per cycle -----
    issue(2, 0, 1, 32'h0, 32'hA0, 0, 0, 32'h0);
    issue(2, 0, 1, 32'h4, 32'hA4, 0, 0, 32'h0);
    issue(2, 0, 1, 32'h8, 32'hA8, 0, 0, 32'h0);
    issue(2, 1, 0, 32'h0, 32'h0,  1, 0, 32'hA0);
    issue(2, 1, 0, 32'h4, 32'h0,  1, 0, 32'hA4);
    issue(2, 1, 0, 32'h8, 32'h0,  1, 0, 32'hA8);
    issue(2, 0, 1, 32'h0, 32'hB0, 1, 0, 32'hA0);
    issue(2, 1, 0, 32'h0, 32'h0,  1, 0, 32'hB0);
    settle(3);

    // Drain with a bounded wait, then report anything still outstanding.
    for (int i = 0; i < 30; i++) begin
      if (q_size(0) + q_size(1) + q_size(2) == 0) break;
      @(negedge clk);
    end
    remain = q_size(0) + q_size(1) + q_size(2);
    check("queues_drained", 32'(remain), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
